// File: rtl/aead_ks_gearbox.sv
// Keystream gearbox for the dual-algorithm AEAD path.
// Requests keystream blocks from the AES or ChaCha engine, packs them into a
// byte FIFO and presents the oldest OUT_W bits to the payload XOR stage, which
// may consume any number of bytes up to OUT_BYTES per cycle.
module aead_ks_gearbox #(
    parameter int OUT_W     = 128,
    parameter int BUF_BYTES = 128,
    parameter int LVL_W     = $clog2(BUF_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic             algo_sel,
    output logic             ks_req,
    input  logic             ks_valid_aes,
    input  logic [127:0]     ks_data_aes,
    input  logic             ks_valid_chacha,
    input  logic [511:0]     ks_data_chacha,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    input  logic [LVL_W-1:0] out_nbytes,
    output logic [LVL_W-1:0] level,
    output logic             err_sticky
);

    localparam int OUT_BYTES = OUT_W / 8;
    localparam int BUF_W     = BUF_BYTES * 8;

    localparam logic [LVL_W-1:0] OUT_BYTES_L = LVL_W'(OUT_BYTES);
    localparam logic [LVL_W-1:0] AES_BLK_L   = LVL_W'(16);
    localparam logic [LVL_W-1:0] CHA_BLK_L   = LVL_W'(64);
    localparam logic [LVL_W:0]   BUF_BYTES_L = (LVL_W + 1)'(BUF_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // Block size in bytes of the selected engine.
    function automatic logic [LVL_W-1:0] blk_bytes(input logic alg);
        logic [LVL_W-1:0] b;
        if (alg) begin
            b = CHA_BLK_L;
        end else begin
            b = AES_BLK_L;
        end
        return b;
    endfunction

    // True when a block of the selected engine still fits behind lvl.
    function automatic logic blk_fits(input logic [LVL_W-1:0] lvl, input logic alg);
        logic [LVL_W:0] need;
        need = {1'b0, lvl} + {1'b0, blk_bytes(alg)};
        return (need <= BUF_BYTES_L);
    endfunction

    state_t           state_r, state_s;
    logic             alg_r;
    logic             drain_alg_r, drain_alg_s;
    logic [BUF_W-1:0] buf_r, buf_s;
    logic [LVL_W-1:0] level_r, level_s;
    logic             err_r, err_s;
    logic             ks_req_r;
    logic             out_valid_r;

    logic             consume_s;
    logic             over_s;
    logic [LVL_W-1:0] n_s;
    logic [LVL_W-1:0] level_after_s;
    logic             eng_valid_s;
    logic             drain_valid_s;
    logic             write_s;
    logic [BUF_W-1:0] blk_ext_s;
    logic [BUF_W-1:0] shifted_s;

    // Consume/write datapath: shift out consumed bytes, append an accepted block.
    always_comb begin
        consume_s     = out_valid_r & out_ready & ~cfg_we;
        over_s        = consume_s & (out_nbytes > OUT_BYTES_L);
        n_s           = '0;
        if (over_s) begin
            n_s = OUT_BYTES_L;
        end else if (consume_s) begin
            n_s = out_nbytes;
        end else begin
            n_s = '0;
        end
        level_after_s = level_r - n_s;

        eng_valid_s   = alg_r ? ks_valid_chacha : ks_valid_aes;
        drain_valid_s = drain_alg_r ? ks_valid_chacha : ks_valid_aes;
        write_s       = (state_r == ST_WAIT) & eng_valid_s & ~cfg_we;

        if (alg_r) begin
            blk_ext_s = BUF_W'(ks_data_chacha);
        end else begin
            blk_ext_s = BUF_W'(ks_data_aes);
        end

        // Bytes above the level are always zero, so a right shift keeps them zero.
        shifted_s = buf_r >> {n_s, 3'b000};

        if (cfg_we) begin
            buf_s   = '0;
            level_s = '0;
            err_s   = 1'b0;
        end else if (write_s) begin
            buf_s   = shifted_s | (blk_ext_s << {level_after_s, 3'b000});
            level_s = level_after_s + blk_bytes(alg_r);
            err_s   = err_r | over_s;
        end else begin
            buf_s   = shifted_s;
            level_s = level_after_s;
            err_s   = err_r | over_s;
        end
    end

    // Request sequencer: one outstanding request, refill only when a whole block fits.
    always_comb begin
        state_s     = state_r;
        drain_alg_s = drain_alg_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_we) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cfg_we) begin
                    state_s     = ST_DRAIN;
                    drain_alg_s = alg_r;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cfg_we) begin
                    state_s     = ST_DRAIN;
                    drain_alg_s = alg_r;
                end else if (eng_valid_s) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if (cfg_we) begin
                    state_s = ST_REQ;
                end else if (blk_fits(level_s, alg_r)) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_DRAIN: begin
                // The stale response belongs to the engine selected before the reconfig.
                if (drain_valid_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, storage and registered outputs; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            alg_r       <= 1'b0;
            drain_alg_r <= 1'b0;
            buf_r       <= '0;
            level_r     <= '0;
            err_r       <= 1'b0;
            ks_req_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            drain_alg_r <= drain_alg_s;
            buf_r       <= buf_s;
            level_r     <= level_s;
            err_r       <= err_s;
            ks_req_r    <= (state_s == ST_REQ);
            out_valid_r <= (level_s >= OUT_BYTES_L);
            if (cfg_we) begin
                alg_r <= algo_sel;
            end else begin
                alg_r <= alg_r;
            end
        end
    end

    assign ks_req     = ks_req_r;
    assign out_valid  = out_valid_r;
    assign out_data   = buf_r[OUT_W-1:0];
    assign level      = level_r;
    assign err_sticky = err_r;

endmodule

// File: tb/tb_aead_ks_gearbox.sv
// Directed bench for aead_ks_gearbox with a fixed-latency model of both engines.
// Keystream byte i of the block answering request id is 8'(id*B + i), so
// consecutive accepted blocks form one continuous byte stream.
module tb_aead_ks_gearbox;

    localparam int LVL_W = 8;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic             algo_sel;
    logic             ks_req;
    logic             ks_valid_aes;
    logic [127:0]     ks_data_aes;
    logic             ks_valid_chacha;
    logic [511:0]     ks_data_chacha;
    logic             out_valid;
    logic [127:0]     out_data;
    logic             out_ready;
    logic [LVL_W-1:0] out_nbytes;
    logic [LVL_W-1:0] level;
    logic             err_sticky;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cnt  = 0;
    int vld_mism = 0;

    logic [LAT-1:0] pipe_v;
    int             pipe_id [LAT];

    typedef struct {
        logic ready;
        int   nbytes;
        int   settle;
        int   exp_level;
        int   exp_pos;
        logic exp_err;
        int   exp_reqs;
    } vec_t;

    vec_t vt [11];

    aead_ks_gearbox #(.OUT_W(128), .BUF_BYTES(128)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_we          (cfg_we),
        .algo_sel        (algo_sel),
        .ks_req          (ks_req),
        .ks_valid_aes    (ks_valid_aes),
        .ks_data_aes     (ks_data_aes),
        .ks_valid_chacha (ks_valid_chacha),
        .ks_data_chacha  (ks_data_chacha),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .out_nbytes      (out_nbytes),
        .level           (level),
        .err_sticky      (err_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] aes_blk(input int id);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(id * 16 + i);
        return r;
    endfunction

    function automatic logic [511:0] cha_blk(input int id);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[i*8 +: 8] = 8'(id * 64 + i);
        return r;
    endfunction

    function automatic logic [127:0] exp_win(input int start);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(start + k);
        return r;
    endfunction

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Engine model: both engines answer every request LAT cycles later.
    always @(posedge clk) begin
        logic seen;
        int   id;
        seen = ks_req;
        id   = req_cnt;
        if (seen) req_cnt++;
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_v[i]  = pipe_v[i-1];
            pipe_id[i] = pipe_id[i-1];
        end
        pipe_v[0]       = seen;
        pipe_id[0]      = id;
        ks_valid_aes    = pipe_v[LAT-1];
        ks_valid_chacha = pipe_v[LAT-1];
        if (pipe_v[LAT-1]) begin
            ks_data_aes    = aes_blk(pipe_id[LAT-1]);
            ks_data_chacha = cha_blk(pipe_id[LAT-1]);
        end
    end

    // out_valid must track level >= OUT_BYTES on every cycle.
    always @(negedge clk) begin
        if (out_valid !== (level >= 8'd16)) vld_mism++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b1, b2, b4, b5, r0, lv;

        pipe_v          = '0;
        rst_n           = 1'b0;
        cfg_we          = 1'b0;
        algo_sel        = 1'b0;
        out_ready       = 1'b0;
        out_nbytes      = '0;
        ks_valid_aes    = 1'b0;
        ks_valid_chacha = 1'b0;
        ks_data_aes     = '0;
        ks_data_chacha  = '0;
        tick(2);
        chk_i("rst_ks_req", int'(ks_req), 0);
        chk_i("rst_out_valid", int'(out_valid), 0);
        chk_i("rst_level", int'(level), 0);
        chk_i("rst_err", int'(err_sticky), 0);
        chk_w("rst_out_data", out_data, 128'd0);
        rst_n = 1'b1;
        tick(3);
        chk_i("idle_no_req", req_cnt, 0);

        // 1: AES fill
        b1 = req_cnt;
        cfg_we = 1'b1; algo_sel = 1'b0;
        tick(1);
        cfg_we = 1'b0;
        chk_i("t1_req_latency", int'(ks_req), 1);
        tick(1);
        chk_i("t1_req_one_cycle", int'(ks_req), 0);
        tick(80);
        chk_i("t1_req_count", req_cnt - b1, 8);
        chk_i("t1_level", int'(level), 128);
        chk_i("t1_out_valid", int'(out_valid), 1);
        chk_w("t1_out_data", out_data, exp_win(b1 * 16));

        // 2: ChaCha fill
        b2 = req_cnt;
        cfg_we = 1'b1; algo_sel = 1'b1;
        tick(1);
        cfg_we = 1'b0;
        chk_i("t2_level_flushed", int'(level), 0);
        chk_i("t2_out_valid_low", int'(out_valid), 0);
        tick(40);
        chk_i("t2_req_count", req_cnt - b2, 2);
        chk_i("t2_level", int'(level), 128);
        chk_w("t2_out_data", out_data, exp_win(b2 * 64));

        // 3: consume table on the full ChaCha buffer
        vt[0]  = '{1'b1,  5,  0, 123,  5, 1'b0, 0};
        vt[1]  = '{1'b0,  0, 10, 123,  5, 1'b0, 0};
        vt[2]  = '{1'b1, 16,  0, 107, 21, 1'b0, 0};
        vt[3]  = '{1'b1, 16,  0,  91, 37, 1'b0, 0};
        vt[4]  = '{1'b1, 16,  0,  75, 53, 1'b0, 0};
        vt[5]  = '{1'b1, 16,  0,  59, 69, 1'b0, 0};
        vt[6]  = '{1'b0,  0, 10, 123, 69, 1'b0, 1};
        vt[7]  = '{1'b1,  0,  2, 123, 69, 1'b0, 0};
        vt[8]  = '{1'b0,  9,  2, 123, 69, 1'b0, 0};
        vt[9]  = '{1'b1, 20,  0, 107, 85, 1'b1, 0};
        vt[10] = '{1'b0,  0, 10, 107, 85, 1'b1, 0};
        for (int i = 0; i < 11; i++) begin
            r0         = req_cnt;
            out_ready  = vt[i].ready;
            out_nbytes = LVL_W'(vt[i].nbytes);
            tick(1);
            out_ready  = 1'b0;
            out_nbytes = '0;
            if (vt[i].settle > 0) tick(vt[i].settle);
            chk_i($sformatf("t3_v%0d_level", i), int'(level), vt[i].exp_level);
            chk_w($sformatf("t3_v%0d_data", i), out_data, exp_win(b2 * 64 + vt[i].exp_pos));
            chk_i($sformatf("t3_v%0d_err", i), int'(err_sticky), int'(vt[i].exp_err));
            chk_i($sformatf("t3_v%0d_reqs", i), req_cnt - r0, vt[i].exp_reqs);
        end

        // 4: reconfigure while waiting on AES, stale AES block must be dropped
        b4 = req_cnt;
        cfg_we = 1'b1; algo_sel = 1'b0;
        tick(1);
        cfg_we = 1'b0;
        tick(1);
        cfg_we = 1'b1; algo_sel = 1'b1;
        tick(1);
        cfg_we = 1'b0;
        chk_i("t4_level_flushed", int'(level), 0);
        chk_i("t4_err_cleared", int'(err_sticky), 0);
        tick(2);
        chk_i("t4_level_after_discard", int'(level), 0);
        chk_i("t4_req_after_discard", int'(ks_req), 1);
        for (int w = 0; w < 40 && level == '0; w++) tick(1);
        lv = int'(level);
        chk_i("t4_first_level", lv, 64);
        chk_i("t4_req_count", req_cnt - b4, 2);
        chk_w("t4_out_data", out_data, exp_win((b4 + 1) * 64));
        tick(40);

        // 5: over-consume, sticky error, flush and reset mid-wait
        out_ready = 1'b1; out_nbytes = 8'd20;
        tick(1);
        out_ready = 1'b0; out_nbytes = '0;
        chk_i("t5_level_clip", int'(level), 112);
        chk_i("t5_err_set", int'(err_sticky), 1);
        chk_w("t5_out_data", out_data, exp_win((b4 + 1) * 64 + 16));
        tick(10);
        chk_i("t5_err_holds", int'(err_sticky), 1);
        chk_i("t5_level_hold", int'(level), 112);
        b5 = req_cnt;
        cfg_we = 1'b1; algo_sel = 1'b0; out_ready = 1'b1; out_nbytes = 8'd20;
        tick(1);
        cfg_we = 1'b0; out_ready = 1'b0; out_nbytes = '0;
        chk_i("t5_cfg_err_clear", int'(err_sticky), 0);
        chk_i("t5_cfg_level", int'(level), 0);
        chk_i("t5_cfg_out_valid", int'(out_valid), 0);
        chk_w("t5_cfg_out_data", out_data, 128'd0);
        tick(80);
        chk_i("t5_aes_reqs", req_cnt - b5, 8);
        chk_i("t5_aes_level", int'(level), 128);
        chk_w("t5_aes_data", out_data, exp_win(b5 * 16));
        cfg_we = 1'b1; algo_sel = 1'b0;
        tick(1);
        cfg_we = 1'b0;
        tick(1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk_i("t5_rst_ks_req", int'(ks_req), 0);
        chk_i("t5_rst_level", int'(level), 0);
        chk_i("t5_rst_out_valid", int'(out_valid), 0);
        chk_i("t5_rst_err", int'(err_sticky), 0);
        chk_w("t5_rst_out_data", out_data, 128'd0);
        r0 = req_cnt;
        tick(15);
        chk_i("t5_idle_no_req", req_cnt - r0, 0);
        chk_i("t5_idle_level", int'(level), 0);

        chk_i("out_valid_tracks_level", vld_mism, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
